// File: rtl/fc_cmd_sequencer.sv
// Request FIFO plus splitter that turns flash/memory transfers into FC commands which never
// cross a 256-byte flash half-page or the 128-byte memory end. Optional macro: FC_SEQ_STATS_EN.
module fc_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dir,
  input  logic [17:0] req_faddr,
  input  logic [6:0]  req_maddr,
  input  logic [8:0]  req_len,
  output logic        req_err,
  input  logic        fc_done,
  output logic [32:0] fc_cmd,
  output logic        fc_cmd_valid,
  output logic        busy
`ifdef FC_SEQ_STATS_EN
  ,
  output logic [15:0] stat_cmds,
  output logic [23:0] stat_bytes
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_ISSUE = 2'd2} state_t;
  localparam int EW = 35;

  state_t               state_q, state_d;
  logic [EW-1:0]        mem_q [DEPTH];
  logic [EW-1:0]        mem_d [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 ready_q, ready_d, err_q, err_d, fc_rdy_q, fc_rdy_d;
  logic                 dir_q, dir_d, valid_q, valid_d, busy_q, busy_d;
  logic [17:0]          fa_q, fa_d;
  logic [6:0]           ma_q, ma_d;
  logic [8:0]           rem_q, rem_d;
  logic [7:0]           chunk_q, chunk_d;
  logic [32:0]          cmd_q, cmd_d;

  logic                 push_s, pop_s, done_s;
  logic [EW-1:0]        head_s;
  logic [8:0]           page_room_s, mem_room_s, min_a_s, chunk_calc_s, chunk_m1_s;

  assign push_s = req_valid & ready_q & (req_len != 9'd0);
  assign pop_s  = (state_q == S_IDLE) & (count_q != {(FIFO_AW+1){1'b0}});
  assign done_s = (state_q == S_ISSUE) & fc_done;
  assign head_s = mem_q[rd_ptr_q];

  // Room to the flash half-page end and to the memory end; both lie in 1..256 / 1..128.
  assign page_room_s  = 9'd256 - {1'b0, fa_q[7:0]};
  assign mem_room_s   = 9'd128 - {2'b00, ma_q};
  assign min_a_s      = (rem_q < page_room_s) ? rem_q : page_room_s;
  assign chunk_calc_s = (min_a_s < mem_room_s) ? min_a_s : mem_room_s;
  assign chunk_m1_s   = chunk_calc_s - 9'd1;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop_s) state_d = S_CALC; else state_d = S_IDLE;
      S_CALC:  if (fc_rdy_q) state_d = S_ISSUE; else state_d = S_CALC;
      S_ISSUE: begin
        if (fc_done) begin
          if (rem_q == {1'b0, chunk_q}) state_d = S_IDLE; else state_d = S_CALC;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, registered from next-state so they line up with the state register
  always_comb begin
    valid_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE) | (count_d != {(FIFO_AW+1){1'b0}});
    ready_d = (count_d != (FIFO_AW+1)'(DEPTH));
    err_d   = req_valid & ready_q & (req_len == 9'd0);
  end

  // FIFO bookkeeping, done flag and the work registers of the transfer in progress
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {req_dir, req_faddr, req_maddr, req_len};
      wr_ptr_d        = wr_ptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(FIFO_AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{FIFO_AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{FIFO_AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    // ISSUE entry consumes the flag even if a done pulse lands in the same cycle
    if ((state_q == S_CALC) && fc_rdy_q) fc_rdy_d = 1'b0;
    else if (fc_done)                     fc_rdy_d = 1'b1;
    else                                  fc_rdy_d = fc_rdy_q;

    dir_d   = dir_q;
    fa_d    = fa_q;
    ma_d    = ma_q;
    rem_d   = rem_q;
    chunk_d = chunk_q;
    cmd_d   = cmd_q;
    if (pop_s) begin
      dir_d = head_s[34];
      fa_d  = head_s[33:16];
      ma_d  = head_s[15:9];
      rem_d = head_s[8:0];
    end else if (state_q == S_CALC) begin
      chunk_d = chunk_calc_s[7:0];
      cmd_d   = {dir_q, fa_q, ma_q, chunk_m1_s[6:0]};
    end else if (done_s) begin
      fa_d  = fa_q + {10'd0, chunk_q};
      ma_d  = ma_q + chunk_q[6:0];
      rem_d = rem_q - {1'b0, chunk_q};
    end else begin
      chunk_d = chunk_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {EW{1'b0}};
      wr_ptr_q <= {FIFO_AW{1'b0}};
      rd_ptr_q <= {FIFO_AW{1'b0}};
      count_q  <= {(FIFO_AW+1){1'b0}};
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      fc_rdy_q <= 1'b0;
      dir_q    <= 1'b0;
      fa_q     <= 18'd0;
      ma_q     <= 7'd0;
      rem_q    <= 9'd0;
      chunk_q  <= 8'd0;
      cmd_q    <= 33'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      fc_rdy_q <= fc_rdy_d;
      dir_q    <= dir_d;
      fa_q     <= fa_d;
      ma_q     <= ma_d;
      rem_q    <= rem_d;
      chunk_q  <= chunk_d;
      cmd_q    <= cmd_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign req_ready    = ready_q;
  assign req_err      = err_q;
  assign fc_cmd       = cmd_q;
  assign fc_cmd_valid = valid_q;
  assign busy         = busy_q;

`ifdef FC_SEQ_STATS_EN
  logic [15:0] stat_cmds_q, stat_cmds_d;
  logic [23:0] stat_bytes_q, stat_bytes_d;
  logic [24:0] bytes_sum_s;

  assign bytes_sum_s = {1'b0, stat_bytes_q} + {17'd0, chunk_q};

  // Saturating completion counters
  always_comb begin
    stat_cmds_d  = stat_cmds_q;
    stat_bytes_d = stat_bytes_q;
    if (done_s) begin
      stat_cmds_d  = (stat_cmds_q == 16'hFFFF) ? stat_cmds_q : (stat_cmds_q + 16'd1);
      stat_bytes_d = bytes_sum_s[24] ? 24'hFF_FFFF : bytes_sum_s[23:0];
    end else begin
      stat_cmds_d  = stat_cmds_q;
      stat_bytes_d = stat_bytes_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cmds_q  <= 16'd0;
      stat_bytes_q <= 24'd0;
    end else begin
      stat_cmds_q  <= stat_cmds_d;
      stat_bytes_q <= stat_bytes_d;
    end
  end

  assign stat_cmds  = stat_cmds_q;
  assign stat_bytes = stat_bytes_q;
`endif

endmodule

// File: tb/tb_fc_cmd_sequencer.sv
// Bench for fc_cmd_sequencer: a splitting model predicts the command stream, checked every
// cycle, alongside directed scenarios with literal expectations for timing and encoding.
module tb_fc_cmd_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_dir;
  logic [17:0] req_faddr;
  logic [6:0]  req_maddr;
  logic [8:0]  req_len;
  logic        req_err;
  logic        fc_done;
  logic [32:0] fc_cmd;
  logic        fc_cmd_valid;
  logic        busy;

  int tests = 0;
  int fails = 0;

  fc_cmd_sequencer #(.DEPTH(4), .FIFO_AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dir      (req_dir),
    .req_faddr    (req_faddr),
    .req_maddr    (req_maddr),
    .req_len      (req_len),
    .req_err      (req_err),
    .fc_done      (fc_done),
    .fc_cmd       (fc_cmd),
    .fc_cmd_valid (fc_cmd_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected command stream and monitor state
  logic [32:0] exp_q [$];
  logic [32:0] cur_cmd;
  bit          cur_active = 1'b0;
  bit          err_exp = 1'b0;
  int          m_fa, m_ma, m_rem, m_ch;

  // Compare process: outputs are registered, inputs change just after posedge, so at the
  // negedge both are stable and describe what the next posedge will do.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur_active = 1'b0;
      err_exp    = 1'b0;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_valid", 64'(fc_cmd_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(req_err), 64'd0);
      chk("rst_cmd", 64'(fc_cmd), 64'd0);
    end else begin
      chk("req_err", 64'(req_err), 64'(err_exp));
      if (fc_cmd_valid) begin
        if (!cur_active) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_cmd: got %0h, expected no command", fc_cmd);
          end else begin
            chk("cmd", 64'(fc_cmd), 64'(exp_q.pop_front()));
          end
          cur_cmd    = fc_cmd;
          cur_active = 1'b1;
        end else begin
          chk("cmd_stable", 64'(fc_cmd), 64'(cur_cmd));
        end
        if (fc_done) cur_active = 1'b0;
      end else if (cur_active) begin
        tests++;
        fails++;
        $display("FAIL valid_dropped: got valid 0, expected 1 until done");
        cur_active = 1'b0;
      end
      err_exp = req_valid && req_ready && (req_len == 9'd0);
      if (req_valid && req_ready && (req_len != 9'd0)) begin
        m_fa  = int'(req_faddr);
        m_ma  = int'(req_maddr);
        m_rem = int'(req_len);
        while (m_rem > 0) begin
          m_ch = m_rem;
          if (256 - (m_fa % 256) < m_ch) m_ch = 256 - (m_fa % 256);
          if (128 - m_ma < m_ch) m_ch = 128 - m_ma;
          exp_q.push_back({req_dir, 18'(m_fa), 7'(m_ma), 7'(m_ch - 1)});
          m_fa  = (m_fa + m_ch) % 262144;
          m_ma  = (m_ma + m_ch) % 128;
          m_rem = m_rem - m_ch;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    fc_done = 1'b1;
    step();
    fc_done = 1'b0;
  endtask

  task automatic send(input logic d, input logic [17:0] fa, input logic [6:0] ma, input logic [8:0] len);
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) chk("send_ready_timeout", 64'(req_ready), 64'd1);
    req_dir   = d;
    req_faddr = fa;
    req_maddr = ma;
    req_len   = len;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!fc_cmd_valid && n < 20) begin
      step();
      n++;
    end
    if (!fc_cmd_valid) chk(name, 64'(fc_cmd_valid), 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_dir = 1'b0; req_faddr = 18'd0;
    req_maddr = 7'd0; req_len = 9'd0; fc_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // 1: single command, 3-cycle latency, held until done
    pulse_done();
    send(1'b1, 18'h00010, 7'h00, 9'd16);
    chk("t1_lat1", 64'(fc_cmd_valid), 64'd0);
    step();
    chk("t1_lat2", 64'(fc_cmd_valid), 64'd0);
    step();
    chk("t1_lat3", 64'(fc_cmd_valid), 64'd1);
    chk("t1_cmd", 64'(fc_cmd), 64'({1'b1, 18'h00010, 7'h00, 7'd15}));
    chk("t1_busy", 64'(busy), 64'd1);
    repeat (3) step();
    chk("t1_hold", 64'(fc_cmd_valid), 64'd1);
    pulse_done();
    chk("t1_valid_off", 64'(fc_cmd_valid), 64'd0);
    chk("t1_busy_off", 64'(busy), 64'd0);

    // 2: flash half-page split, back-to-back chunk latency
    send(1'b0, 18'h000F0, 7'h00, 9'd64);
    wait_valid("t2_wait1");
    chk("t2_cmd1", 64'(fc_cmd), 64'({1'b0, 18'h000F0, 7'h00, 7'd15}));
    pulse_done();
    chk("t2_gap", 64'(fc_cmd_valid), 64'd0);
    step();
    chk("t2_b2b", 64'(fc_cmd_valid), 64'd1);
    chk("t2_cmd2", 64'(fc_cmd), 64'({1'b0, 18'h00100, 7'd16, 7'd47}));
    pulse_done();

    // 3: memory end split with maddr wrap
    send(1'b0, 18'h00000, 7'h70, 9'd40);
    wait_valid("t3_wait1");
    chk("t3_cmd1", 64'(fc_cmd), 64'({1'b0, 18'h00000, 7'h70, 7'd15}));
    pulse_done();
    wait_valid("t3_wait2");
    chk("t3_cmd2", 64'(fc_cmd), 64'({1'b0, 18'h00010, 7'h00, 7'd23}));
    pulse_done();

    // 4: maximum length gives two 128-byte commands
    send(1'b1, 18'h00000, 7'h00, 9'd256);
    wait_valid("t4_wait1");
    chk("t4_len1", 64'(fc_cmd[6:0]), 64'd127);
    pulse_done();
    wait_valid("t4_wait2");
    chk("t4_cmd2", 64'(fc_cmd), 64'({1'b1, 18'h00080, 7'h00, 7'd127}));
    pulse_done();
    step();

    // 5: fill the FIFO, zero-length drop
    for (int i = 0; i < 5; i++) send(1'b0, 18'(32'h1000 + i * 8), 7'h00, 9'd8);
    chk("t5_full", 64'(req_ready), 64'd0);
    chk("t5_issuing", 64'(fc_cmd_valid), 64'd1);
    chk("t5_busy", 64'(busy), 64'd1);
    pulse_done();
    chk("t5_still_full", 64'(req_ready), 64'd0);
    step();
    chk("t5_slot_free", 64'(req_ready), 64'd1);
    send(1'b1, 18'h3FFFF, 7'h00, 9'd0);
    chk("t5_err_pulse", 64'(req_err), 64'd1);
    step();
    chk("t5_err_end", 64'(req_err), 64'd0);
    chk("t5_not_pushed", 64'(req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      wait_valid("t5_drain");
      pulse_done();
    end
    step();
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_model_empty", 64'(exp_q.size()), 64'd0);

    // 6: reset during chunk 2 of 3
    send(1'b1, 18'h000F0, 7'h00, 9'd200);
    wait_valid("t6_wait1");
    pulse_done();
    wait_valid("t6_wait2");
    chk("t6_cmd2", 64'(fc_cmd), 64'({1'b1, 18'h00100, 7'd16, 7'd111}));
    rst = 1'b1;
    #1;
    chk("t6_valid_drop", 64'(fc_cmd_valid), 64'd0);
    chk("t6_busy_drop", 64'(busy), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    pulse_done();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_no_stale", 64'(fc_cmd_valid), 64'd0);
    end
    chk("t6_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
